// File: rtl/mux_n_stream.sv
// mux_n_stream: N-channel valid/ready stream multiplexer with a registered output stage.
// MODE 0 forwards the channel named by sel, MODE 1 round-robins; `MUX_CH_TAG_EN adds out_ch.
module mux_n_stream #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data
`ifdef MUX_CH_TAG_EN
  ,
  output logic [SEL_W-1:0]      out_ch
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef MUX_CH_TAG_EN
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
`endif

  logic             load;
  logic             pick_ok;
  logic [SEL_W-1:0] pick_idx;
  logic             xfer;
  logic [WIDTH-1:0] pick_data;
  logic [WIDTH-1:0] ch_data [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The output register accepts a new word whenever it is empty or being drained.
  assign load = !out_valid_q | out_ready;

  always_comb begin : chooser
    int idx;
    idx      = 0;
    pick_ok  = 1'b0;
    pick_idx = '0;
    if (MODE == 1) begin
      // Scan from rr_ptr upwards; wrap by compare so non-power-of-2 N_CH works.
      for (int off = 0; off < N_CH; off++) begin
        idx = int'(rr_ptr_q) + off;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!pick_ok && in_valid[idx]) begin
          pick_ok  = 1'b1;
          pick_idx = SEL_W'(idx);
        end
      end
    end else if (N_CH == 1) begin
      pick_ok = 1'b1;
    end else if (int'(sel) < N_CH) begin
      pick_ok  = 1'b1;
      pick_idx = sel;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
      assign in_ready[gi] = !rst && load && pick_ok && (pick_idx == SEL_W'(gi)) &&
                            ((MODE != 1) || in_valid[gi]);
    end
  endgenerate

  assign xfer      = |(in_valid & in_ready);
  assign pick_data = ch_data[pick_idx];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef MUX_CH_TAG_EN
    out_ch_d    = out_ch_q;
`endif
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = pick_data;
`ifdef MUX_CH_TAG_EN
        out_ch_d   = pick_idx;
`endif
      end
    end
    if ((MODE == 1) && xfer) begin
      rr_ptr_d = (int'(pick_idx) == N_CH - 1) ? '0 : pick_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
`ifdef MUX_CH_TAG_EN
      out_ch_q    <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_CH_TAG_EN
      out_ch_q    <= out_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef MUX_CH_TAG_EN
  assign out_ch    = out_ch_q;
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
// Bench for mux_n_stream: three instances (MODE0 N_CH=6, MODE1 N_CH=4, MODE1 N_CH=3)
// driven by directed steps then random traffic, checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_mux_n_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Generic per-instance stimulus (index 0 = A, 1 = B, 2 = C)
  logic [7:0] v_in [3];
  logic [7:0] d_in [3][6];
  logic [2:0] s_in [3];
  logic       r_in [3];

  // Instance A: MODE0, N_CH=6
  logic [2:0]  a_sel;
  logic [5:0]  a_valid, a_ready;
  logic [47:0] a_data;
  logic        a_ov;
  logic [7:0]  a_od;
  logic [2:0]  a_och;
  // Instance B: MODE1, N_CH=4
  logic [1:0]  b_sel;
  logic [3:0]  b_valid, b_ready;
  logic [31:0] b_data;
  logic        b_ov;
  logic [7:0]  b_od;
  logic [1:0]  b_och;
  // Instance C: MODE1, N_CH=3
  logic [1:0]  c_sel;
  logic [2:0]  c_valid, c_ready;
  logic [23:0] c_data;
  logic        c_ov;
  logic [7:0]  c_od;
  logic [1:0]  c_och;

  always_comb begin
    a_sel   = s_in[0];
    b_sel   = s_in[1][1:0];
    c_sel   = s_in[2][1:0];
    a_valid = v_in[0][5:0];
    b_valid = v_in[1][3:0];
    c_valid = v_in[2][2:0];
    a_data  = '0;
    b_data  = '0;
    c_data  = '0;
    for (int i = 0; i < 6; i++) a_data[i*8 +: 8] = d_in[0][i];
    for (int i = 0; i < 4; i++) b_data[i*8 +: 8] = d_in[1][i];
    for (int i = 0; i < 3; i++) c_data[i*8 +: 8] = d_in[2][i];
  end

  mux_n_stream #(.N_CH(6), .WIDTH(8), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .sel(a_sel), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .out_valid(a_ov), .out_ready(r_in[0]), .out_data(a_od)
`ifdef MUX_CH_TAG_EN
    , .out_ch(a_och)
`endif
  );
  mux_n_stream #(.N_CH(4), .WIDTH(8), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .sel(b_sel), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .out_valid(b_ov), .out_ready(r_in[1]), .out_data(b_od)
`ifdef MUX_CH_TAG_EN
    , .out_ch(b_och)
`endif
  );
  mux_n_stream #(.N_CH(3), .WIDTH(8), .MODE(1)) u_c (
    .clk(clk), .rst(rst), .sel(c_sel), .in_valid(c_valid), .in_data(c_data),
    .in_ready(c_ready), .out_valid(c_ov), .out_ready(r_in[2]), .out_data(c_od)
`ifdef MUX_CH_TAG_EN
    , .out_ch(c_och)
`endif
  );
`ifndef MUX_CH_TAG_EN
  assign a_och = '0;
  assign b_och = '0;
  assign c_och = '0;
`endif

  function automatic int nch(int k);
    return (k == 0) ? 6 : ((k == 1) ? 4 : 3);
  endfunction
  function automatic int mode(int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic logic [7:0] get_rdy(int k);
    case (k)
      0:       return {2'b0, a_ready};
      1:       return {4'b0, b_ready};
      default: return {5'b0, c_ready};
    endcase
  endfunction
  function automatic logic [7:0] get_ov(int k);
    case (k)
      0:       return {7'b0, a_ov};
      1:       return {7'b0, b_ov};
      default: return {7'b0, c_ov};
    endcase
  endfunction
  function automatic logic [7:0] get_od(int k);
    case (k)
      0:       return a_od;
      1:       return b_od;
      default: return c_od;
    endcase
  endfunction
  function automatic logic [7:0] get_och(int k);
    case (k)
      0:       return {5'b0, a_och};
      1:       return {6'b0, b_och};
      default: return {6'b0, c_och};
    endcase
  endfunction

  // Reference model state: what the output register should hold, and the round-robin pointer.
  logic       m_v [3];
  logic [7:0] m_d [3];
  int         m_c [3];
  int         m_p [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = 8'h00;
      m_c[k] = 0;
      m_p[k] = 0;
    end
  endtask

  // Channel the rules select this cycle, or -1 when none.
  function automatic int pick(int k);
    int n;
    n = nch(k);
    if (mode(k) == 0) begin
      if (n == 1) return 0;
      return (int'(s_in[k]) < n) ? int'(s_in[k]) : -1;
    end
    for (int off = 0; off < n; off++) begin
      if (v_in[k][(m_p[k] + off) % n]) return (m_p[k] + off) % n;
    end
    return -1;
  endfunction

  task automatic check(string tag, int k, logic [7:0] got, logic [7:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s inst%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // One clock: inputs already driven just after the previous edge.
  task automatic step();
    int         c  [3];
    logic       ld [3];
    logic       x  [3];
    logic [7:0] er;
    #4;
    for (int k = 0; k < 3; k++) begin
      ld[k] = !m_v[k] || r_in[k];
      c[k]  = pick(k);
      er    = 8'h00;
      if (ld[k] && c[k] >= 0 && (mode(k) == 0 || v_in[k][c[k]])) er = 8'd1 << c[k];
      check("in_ready", k, get_rdy(k), er);
      x[k] = (er != 8'h00) && v_in[k][c[k]];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (ld[k]) begin
        m_v[k] = x[k];
        if (x[k]) begin
          m_d[k] = d_in[k][c[k]];
          m_c[k] = c[k];
          if (mode(k) == 1) m_p[k] = (c[k] + 1) % nch(k);
        end
      end
      check("out_valid", k, get_ov(k), {7'b0, m_v[k]});
      check("out_data", k, get_od(k), m_d[k]);
`ifdef MUX_CH_TAG_EN
      check("out_ch", k, get_och(k), 8'(m_c[k]));
`endif
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      v_in[k] = 8'h00;
      s_in[k] = 3'd0;
      r_in[k] = 1'b1;
      for (int i = 0; i < 6; i++) d_in[k][i] = 8'h00;
    end
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) v_in[k] = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", k, get_rdy(k), 8'h00);
      check("rst_valid", k, get_ov(k), 8'h00);
      check("rst_data", k, get_od(k), 8'h00);
    end
    rst = 1'b0;
    idle();

    // Select channel 2 of A
    s_in[0] = 3'd2;
    v_in[0] = 8'b0000_0100;
    d_in[0][2] = 8'hA5;
    step();
    check("t1_data", 0, a_od, 8'hA5);

    // Stall with sel moving to channel 1; held word must not change
    r_in[0] = 1'b0;
    s_in[0] = 3'd1;
    v_in[0] = 8'b0000_0010;
    d_in[0][1] = 8'h3C;
    for (int j = 0; j < 3; j++) begin
      step();
      check("t2_hold", 0, a_od, 8'hA5);
    end
    r_in[0] = 1'b1;
    step();
    check("t2_next", 0, a_od, 8'h3C);

    // Out-of-range select drains the current word and then idles
    s_in[0] = 3'd6;
    v_in[0] = 8'h3F;
    step();
    check("t3_valid", 0, {7'b0, a_ov}, 8'h00);
    s_in[0] = 3'd7;
    step();
    check("t3_keep", 0, a_od, 8'h3C);

    // Round robin with every channel valid
    idle();
    v_in[1] = 8'h0F;
    for (int i = 0; i < 4; i++) d_in[1][i] = 8'h10 + 8'(i);
    for (int j = 0; j < 5; j++) begin
      step();
      check("t4_seq", 1, b_od, 8'h10 + 8'(j % 4));
    end

    // Only ch1 and ch3 valid, starting from pointer 2
    v_in[1] = 8'b0000_0010;
    step();
    check("t5_pre", 1, b_od, 8'h11);
    v_in[1] = 8'b0000_1010;
    step();
    check("t5_a", 1, b_od, 8'h13);
    step();
    check("t5_b", 1, b_od, 8'h11);
    step();
    check("t5_c", 1, b_od, 8'h13);

    // Move the pointer off zero, stall, then reset mid-stall
    v_in[1] = 8'b0000_0010;
    step();
    r_in[1] = 1'b0;
    v_in[1] = 8'h0F;
    step();
    check("t6_stall", 1, b_od, 8'h11);
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check("t6_valid", k, get_ov(k), 8'h00);
      check("t6_data", k, get_od(k), 8'h00);
      check("t6_ready", k, get_rdy(k), 8'h00);
      check("t6_ch", k, get_och(k), 8'h00);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    r_in[1] = 1'b1;
    step();
    check("t6_ch0", 1, b_od, 8'h10);

    // Random traffic on all three instances
    for (int j = 0; j < 400; j++) begin
      for (int k = 0; k < 3; k++) begin
        v_in[k] = 8'($urandom);
        s_in[k] = 3'($urandom_range(0, 7));
        r_in[k] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 6; i++) d_in[k][i] = 8'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
